// File: rtl/srv_tcm_arb.sv
// Two-port arbiter in front of one 64-bit single-port TCM macro.
// Define SRV_TCM_ARB_RR_EN for round-robin; default is fixed priority with a starvation guard.
module srv_tcm_arb #(
  parameter int AW_TCM     = 16,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [AW_TCM-1:0] p0_req_addr,
  input  logic [63:0]       p0_req_bwe,
  input  logic [63:0]       p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [63:0]       p0_rsp_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [AW_TCM-1:0] p1_req_addr,
  input  logic [63:0]       p1_req_bwe,
  input  logic [63:0]       p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [63:0]       p1_rsp_rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [AW_TCM-1:0] sram_addr,
  output logic [63:0]       sram_bwe,
  output logic [63:0]       sram_din,
  input  logic [63:0]       sram_dout
);

  logic w_v0;
  logic w_v1;
  logic w_g0;
  logic w_g1;
  logic w_any;

  // Requests are masked while in reset so every output reads 0.
  assign w_v0 = p0_req_valid & reset_n;
  assign w_v1 = p1_req_valid & reset_n;

`ifdef SRV_TCM_ARB_RR_EN
  logic r_last;

  assign w_g1 = w_v1 & (~w_v0 | ~r_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b0;
    end else if (w_any) begin
      r_last <= w_g1;
    end
  end
`else
  localparam int WCW = $clog2(STARVE_LIM + 1);
  localparam logic [WCW-1:0] LIM = WCW'(STARVE_LIM);

  logic [WCW-1:0] r_wait;
  logic           w_force;

  assign w_force = (r_wait == LIM);
  assign w_g1    = w_v1 & (~w_v0 | w_force);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait <= '0;
    end else if (!w_v1 || w_g1) begin
      r_wait <= '0;
    end else if (!w_force) begin
      r_wait <= r_wait + 1'b1;
    end
  end
`endif

  assign w_g0  = w_v0 & ~w_g1;
  assign w_any = w_g0 | w_g1;

  assign p0_req_ready = w_g0;
  assign p1_req_ready = w_g1;
  assign sram_ce      = w_any;

  always_comb begin
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_bwe  = '0;
    sram_din  = '0;
    unique case (1'b1)
      w_g0: begin
        sram_we   = p0_req_we;
        sram_addr = p0_req_addr;
        sram_bwe  = p0_req_bwe;
        sram_din  = p0_req_wdata;
      end
      w_g1: begin
        sram_we   = p1_req_we;
        sram_addr = p1_req_addr;
        sram_bwe  = p1_req_bwe;
        sram_din  = p1_req_wdata;
      end
      default: begin
        sram_we   = 1'b0;
      end
    endcase
  end

  logic r_rsp_vld;
  logic r_rsp_id;
  logic r_rsp_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= 1'b0;
      r_rsp_rd  <= 1'b0;
    end else begin
      r_rsp_vld <= w_any;
      r_rsp_id  <= w_g1;
      r_rsp_rd  <= w_any & ~sram_we;
    end
  end

  assign p0_rsp_valid = r_rsp_vld & ~r_rsp_id;
  assign p1_rsp_valid = r_rsp_vld & r_rsp_id;
  assign p0_rsp_rdata = (p0_rsp_valid & r_rsp_rd) ? sram_dout : 64'd0;
  assign p1_rsp_rdata = (p1_rsp_valid & r_rsp_rd) ? sram_dout : 64'd0;

endmodule

// File: tb/tb_srv_tcm_arb.sv
// Scoreboard bench for srv_tcm_arb: directed scenarios plus random two-port traffic.
// Honours SRV_TCM_ARB_RR_EN the same way as the design.
module tb_srv_tcm_arb;
  localparam int AW  = 16;
  localparam int LIM = 8;

  logic          clk = 0;
  logic          reset_n = 0;
  logic          p0_req_valid = 0;
  logic          p0_req_ready;
  logic          p0_req_we = 0;
  logic [AW-1:0] p0_req_addr = '0;
  logic [63:0]   p0_req_bwe = '0;
  logic [63:0]   p0_req_wdata = '0;
  logic          p0_rsp_valid;
  logic [63:0]   p0_rsp_rdata;
  logic          p1_req_valid = 0;
  logic          p1_req_ready;
  logic          p1_req_we = 0;
  logic [AW-1:0] p1_req_addr = '0;
  logic [63:0]   p1_req_bwe = '0;
  logic [63:0]   p1_req_wdata = '0;
  logic          p1_rsp_valid;
  logic [63:0]   p1_rsp_rdata;
  logic          sram_ce;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [63:0]   sram_bwe;
  logic [63:0]   sram_din;
  logic [63:0]   sram_dout = '0;

  srv_tcm_arb #(.AW_TCM(AW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
    .p0_req_bwe(p0_req_bwe), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
    .p1_req_bwe(p1_req_bwe), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_bwe(sram_bwe), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural single-port SRAM, one-cycle read latency.
  logic [63:0] sram_m [int];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        logic [63:0] old;
        old = sram_m.exists(int'(sram_addr)) ? sram_m[int'(sram_addr)] : 64'd0;
        sram_m[int'(sram_addr)] = (old & ~sram_bwe) | (sram_din & sram_bwe);
      end else begin
        sram_dout <= sram_m.exists(int'(sram_addr)) ? sram_m[int'(sram_addr)] : 64'd0;
      end
    end
  end

  // Reference model: memory image, grant rule state, expected responses.
  typedef struct {
    int          port;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [63:0] ref_m [int];
  int          m_wait = 0;
  bit          m_last = 0;

  function automatic logic [63:0] ref_rd(input logic [AW-1:0] a);
    return ref_m.exists(int'(a)) ? ref_m[int'(a)] : 64'd0;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      m_wait = 0;
      m_last = 0;
    end else begin
      bit e0, e1, ewe;
      logic [AW-1:0] ea;
      logic [63:0] eb, ed;
      exp_t it;
`ifdef SRV_TCM_ARB_RR_EN
      e1 = p1_req_valid && (!p0_req_valid || !m_last);
`else
      e1 = p1_req_valid && (!p0_req_valid || m_wait == LIM);
`endif
      e0 = p0_req_valid && !e1;
      ewe = 0; ea = '0; eb = '0; ed = '0;
      if (e0) begin
        ewe = p0_req_we; ea = p0_req_addr;
        eb = p0_req_bwe; ed = p0_req_wdata;
      end else if (e1) begin
        ewe = p1_req_we; ea = p1_req_addr;
        eb = p1_req_bwe; ed = p1_req_wdata;
      end
      chk("p0_req_ready", 64'(p0_req_ready), 64'(e0));
      chk("p1_req_ready", 64'(p1_req_ready), 64'(e1));
      chk("sram_ce", 64'(sram_ce), 64'(e0 | e1));
      chk("sram_we", 64'(sram_we), 64'(ewe));
      chk("sram_addr", 64'(sram_addr), 64'(ea));
      chk("sram_bwe", sram_bwe, eb);
      chk("sram_din", sram_din, ed);
      if (p1_req_valid && !e1) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
      else m_wait = 0;
      if (e0 || e1) begin
        m_last = e1;
        it.port = e1 ? 1 : 0;
        it.cyc = cyc;
        if (ewe) begin
          ref_m[int'(ea)] = (ref_rd(ea) & ~eb) | (ed & eb);
          it.data = 64'd0;
        end else begin
          it.data = ref_rd(ea);
        end
        q.push_back(it);
      end
    end
  end

  // Monitor: every accepted request must answer on the next cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      bit x0, x1;
      logic [63:0] d0, d1;
      exp_t it;
      x0 = 0; x1 = 0; d0 = '0; d1 = '0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        it = q.pop_front();
        if (it.port == 0) begin x0 = 1; d0 = it.data; end
        else begin x1 = 1; d1 = it.data; end
      end
      chk("p0_rsp_valid", 64'(p0_rsp_valid), 64'(x0));
      chk("p1_rsp_valid", 64'(p1_rsp_valid), 64'(x1));
      chk("p0_rsp_rdata", p0_rsp_rdata, d0);
      chk("p1_rsp_rdata", p1_rsp_rdata, d1);
    end
  end

  int run1 = 0;
  int max_run1 = 0;
  always @(negedge clk) begin
    if (!reset_n) run1 = 0;
    else if (p1_req_valid && !p1_req_ready) run1++;
    else run1 = 0;
    if (run1 > max_run1) max_run1 = run1;
  end

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [63:0] bwe, input logic [63:0] wd,
                       output int gc);
    bit ok;
    ok = 0;
    gc = -1;
    if (p == 0) begin
      p0_req_valid = 1; p0_req_we = we; p0_req_addr = a;
      p0_req_bwe = bwe; p0_req_wdata = wd;
    end else begin
      p1_req_valid = 1; p1_req_we = we; p1_req_addr = a;
      p1_req_bwe = bwe; p1_req_wdata = wd;
    end
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      if ((p == 0 && p0_req_ready) || (p == 1 && p1_req_ready)) begin
        ok = 1;
        gc = cyc;
      end
      @(posedge clk); #1;
    end
    if (p == 0) p0_req_valid = 0;
    else p1_req_valid = 0;
    chk($sformatf("grant_timeout_p%0d", p), 64'(ok), 64'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic rand_port(input int p, input int n);
    int g;
    logic [63:0] b;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) next_cycle();
      b = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
      issue(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
            b, {$urandom, $urandom}, g);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, start, p0first;
    int p1g[$];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_p0_rsp_valid", 64'(p0_rsp_valid), 64'd0);
    chk("rst_p1_rsp_valid", 64'(p1_rsp_valid), 64'd0);
    chk("rst_sram_ce", 64'(sram_ce), 64'd0);
    chk("rst_p0_rsp_rdata", p0_rsp_rdata, 64'd0);
    @(posedge clk); #1;
    reset_n = 1;
    next_cycle();

    // Continuous contention: grant pattern
    start = cyc;
    p0first = -1;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          issue(0, 1'b0, 16'h0040, '0, '0, g);
          if (k == 0) p0first = g;
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          issue(1, 1'b0, 16'h0041, '0, '0, g);
          p1g.push_back(g);
        end
      end
    join
`ifdef SRV_TCM_ARB_RR_EN
    chk("rr_p1_first", 64'(p1g[0] - start), 64'd0);
    chk("rr_p0_first", 64'(p0first - start), 64'd1);
    chk("rr_p1_second", 64'(p1g[1] - start), 64'd2);
`else
    chk("fix_p0_first", 64'(p0first - start), 64'd0);
    chk("fix_p1_first", 64'(p1g[0] - start), 64'd8);
    chk("fix_p1_second", 64'(p1g[1] - start), 64'd17);
`endif

    // Full-word write then read back on port 0
    issue(0, 1'b1, 16'h0010, '1, 64'hDEAD_BEEF_0123_4567, g);
    issue(0, 1'b0, 16'h0010, '0, '0, g);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(p0_rsp_valid), 64'd1);
    chk("t1_rdata", p0_rsp_rdata, 64'hDEAD_BEEF_0123_4567);
    next_cycle();

    // Partial bit-enable write on port 1
    issue(1, 1'b1, 16'h00FF, 64'h0000_0000_FFFF_FFFF, '1, g);
    issue(1, 1'b0, 16'h00FF, '0, '0, g);
    @(negedge clk);
    chk("t2_rsp_valid", 64'(p1_rsp_valid), 64'd1);
    chk("t2_rdata", p1_rsp_rdata, 64'h0000_0000_FFFF_FFFF);
    next_cycle();

    // Same-address write (p0) and read (p1) in the same cycle
    fork
      issue(0, 1'b1, 16'h0020, '1, 64'h1, g);
      issue(1, 1'b0, 16'h0020, '0, '0, g);
    join
    @(negedge clk);
    chk("t6_rsp_valid", 64'(p1_rsp_valid), 64'd1);
    chk("t6_rdata", p1_rsp_rdata, 64'h1);
    next_cycle();

    // Reset with a read response in flight
    p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 16'h0010;
    @(negedge clk);
    chk("t5_accept", 64'(p0_req_ready), 64'd1);
    @(posedge clk); #1;
    reset_n = 0;
    q.delete();
    @(negedge clk);
    chk("t5_p0_ready", 64'(p0_req_ready), 64'd0);
    chk("t5_p0_rsp_valid", 64'(p0_rsp_valid), 64'd0);
    chk("t5_p0_rsp_rdata", p0_rsp_rdata, 64'd0);
    chk("t5_sram_ce", 64'(sram_ce), 64'd0);
    chk("t5_sram_addr", 64'(sram_addr), 64'd0);
    @(posedge clk); #1;
    p0_req_valid = 0;
    reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_post_p0_rsp", 64'(p0_rsp_valid), 64'd0);
      chk("t5_post_p1_rsp", 64'(p1_rsp_valid), 64'd0);
    end
    next_cycle();

    // Random two-port traffic
    fork
      rand_port(0, 300);
      rand_port(1, 300);
    join
    repeat (3) next_cycle();

`ifndef SRV_TCM_ARB_RR_EN
    chk("p1_max_wait_le_lim", 64'(max_run1 <= LIM), 64'd1);
`endif
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
